// File: rtl/fetch_ctrl_if.sv
// Signal bundle between the Y86-64 fetch sequencer and its pipeline neighbours.
// The master side drives fetch/hazard status; the slave side is fetch_ctrl itself.
interface fetch_ctrl_if;
  logic [3:0]  f_icode;
  logic [63:0] f_valC;
  logic [63:0] f_valP;
  logic        f_hlt;
  logic        f_imem_error;
  logic        f_instr_valid;
  logic        load_use;
  logic        m_mispredict;
  logic [63:0] m_valA;
  logic        w_ret;
  logic [63:0] w_valM;
  logic [63:0] PC;
  logic        f_stall;
  logic        d_stall;
  logic        d_bubble;
  logic [2:0]  stat;
  logic [1:0]  state;
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_bubble_cnt;

  modport master (
    output f_icode, f_valC, f_valP, f_hlt, f_imem_error, f_instr_valid,
    output load_use, m_mispredict, m_valA, w_ret, w_valM,
    input  PC, f_stall, d_stall, d_bubble, stat, state,
    input  perf_stall_cnt, perf_bubble_cnt
  );

  modport slave (
    input  f_icode, f_valC, f_valP, f_hlt, f_imem_error, f_instr_valid,
    input  load_use, m_mispredict, m_valA, w_ret, w_valM,
    output PC, f_stall, d_stall, d_bubble, stat, state,
    output perf_stall_cnt, perf_bubble_cnt
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Y86-64 fetch sequencer: predicted-PC register, redirect priority, F/D stall/bubble and halt status.
// Optional stall/bubble performance counters are built when FETCH_CTRL_PERF_EN is defined.
module fetch_ctrl #(
  parameter logic [63:0] RESET_PC     = 64'd0,
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input logic         clk,
  input logic         rst,
  fetch_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_RET_WAIT = 2'd1,
    ST_DRAIN    = 2'd2,
    ST_HALT     = 2'd3
  } state_e;

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;
  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [2:0]  stat_q, stat_d;
  logic [3:0]  drain_cnt_q, drain_cnt_d;
  logic [63:0] pred_pc;
  logic        f_stall, d_stall, d_bubble;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      pc_q        <= RESET_PC;
      stat_q      <= STAT_AOK;
      drain_cnt_q <= 4'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      stat_q      <= stat_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  always_comb begin
    pred_pc     = ((bus.f_icode == 4'd7) || (bus.f_icode == 4'd8)) ? bus.f_valC : bus.f_valP;
    state_d     = state_q;
    pc_d        = pc_q;
    stat_d      = stat_q;
    drain_cnt_d = drain_cnt_q;
    if (state_q == ST_HALT) begin
      // Terminal: only reset leaves HALT.
    end else if (bus.m_mispredict) begin
      pc_d        = bus.m_valA;
      state_d     = ST_RUN;
      stat_d      = STAT_AOK;
      drain_cnt_d = 4'd0;
    end else if ((state_q == ST_RET_WAIT) && bus.w_ret) begin
      pc_d    = bus.w_valM;
      state_d = ST_RUN;
    end else if (bus.load_use) begin
      // Whole sequencer freezes, including the drain countdown.
    end else begin
      case (state_q)
        ST_RUN: begin
          if (bus.f_imem_error) begin
            stat_d      = STAT_ADR;
            state_d     = ST_DRAIN;
            drain_cnt_d = DRAIN_LOAD;
          end else if (!bus.f_instr_valid) begin
            stat_d      = STAT_INS;
            state_d     = ST_DRAIN;
            drain_cnt_d = DRAIN_LOAD;
          end else if (bus.f_hlt) begin
            stat_d      = STAT_HLT;
            state_d     = ST_DRAIN;
            drain_cnt_d = DRAIN_LOAD;
          end else begin
            pc_d = pred_pc;
            if (bus.f_icode == 4'd9) state_d = ST_RET_WAIT;
          end
        end
        ST_DRAIN: begin
          if (drain_cnt_q == 4'd0) state_d = ST_HALT;
          else drain_cnt_d = drain_cnt_q - 4'd1;
        end
        default: ;
      endcase
    end
  end

  // Bubbles beat load_use outside RUN, so d_stall can only rise in RUN.
  always_comb begin
    f_stall  = 1'b0;
    d_stall  = 1'b0;
    d_bubble = 1'b0;
    if (!rst) begin
      if (state_q == ST_HALT) begin
        f_stall  = 1'b1;
        d_bubble = 1'b1;
      end else if (bus.m_mispredict) begin
        d_bubble = 1'b1;
      end else if ((state_q == ST_RET_WAIT) && bus.w_ret) begin
        d_bubble = 1'b0;
      end else if ((state_q == ST_RET_WAIT) || (state_q == ST_DRAIN)) begin
        f_stall  = 1'b1;
        d_bubble = 1'b1;
      end else if (bus.load_use) begin
        f_stall = 1'b1;
        d_stall = 1'b1;
      end
    end
  end

  assign bus.PC       = pc_q;
  assign bus.stat     = stat_q;
  assign bus.state    = state_q;
  assign bus.f_stall  = f_stall;
  assign bus.d_stall  = d_stall;
  assign bus.d_bubble = d_bubble;

`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_bubble_q, perf_bubble_d;

  always_comb begin
    perf_stall_d  = perf_stall_q + {31'd0, f_stall};
    perf_bubble_d = perf_bubble_q + {31'd0, d_bubble};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q  <= 32'd0;
      perf_bubble_q <= 32'd0;
    end else begin
      perf_stall_q  <= perf_stall_d;
      perf_bubble_q <= perf_bubble_d;
    end
  end

  assign bus.perf_stall_cnt  = perf_stall_q;
  assign bus.perf_bubble_cnt = perf_bubble_q;
`else
  assign bus.perf_stall_cnt  = 32'd0;
  assign bus.perf_bubble_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: registered results go through an expected queue,
// combinational controls are checked just before each active edge.
module tb_fetch_ctrl;
  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   step_no;
  logic [68:0] exp_q[$];
  logic [31:0] exp_stall_cnt;
  logic [31:0] exp_bubble_cnt;

  fetch_ctrl_if bus ();

  fetch_ctrl #(.RESET_PC(64'h20), .DRAIN_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL step %0d %s got=%h exp=%h", step_no, tag, got, exp);
    end
  endtask

  task automatic fetch(input logic [3:0] icode, input logic [63:0] valc, input logic [63:0] valp);
    bus.f_icode       = icode;
    bus.f_valC        = valc;
    bus.f_valP        = valp;
    bus.f_hlt         = (icode == 4'd0);
    bus.f_imem_error  = 1'b0;
    bus.f_instr_valid = 1'b1;
  endtask

  task automatic compare_regs();
    logic [68:0] e;
    if (exp_q.size() == 0) begin
      check("queue_empty", 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      check("pc", bus.PC, e[68:5]);
      check("state", {62'd0, bus.state}, {62'd0, e[4:3]});
      check("stat", {61'd0, bus.stat}, {61'd0, e[2:0]});
    end
    check("perf_stall", {32'd0, bus.perf_stall_cnt}, {32'd0, exp_stall_cnt});
    check("perf_bubble", {32'd0, bus.perf_bubble_cnt}, {32'd0, exp_bubble_cnt});
  endtask

  // Called at a negedge; ectl = {f_stall, d_stall, d_bubble}.
  task automatic step(input logic ld, input logic mp, input logic [63:0] mva,
                      input logic wr, input logic [63:0] wvm, input logic [2:0] ectl,
                      input logic [63:0] epc, input logic [1:0] est, input logic [2:0] estat);
    step_no++;
    bus.load_use     = ld;
    bus.m_mispredict = mp;
    bus.m_valA       = mva;
    bus.w_ret        = wr;
    bus.w_valM       = wvm;
    #2;
    check("ctl", {61'd0, bus.f_stall, bus.d_stall, bus.d_bubble}, {61'd0, ectl});
    exp_q.push_back({epc, est, estat});
`ifdef FETCH_CTRL_PERF_EN
    exp_stall_cnt  = exp_stall_cnt + {31'd0, ectl[2]};
    exp_bubble_cnt = exp_bubble_cnt + {31'd0, ectl[0]};
`endif
    @(posedge clk);
    #1;
    compare_regs();
    @(negedge clk);
  endtask

  task automatic reset_step();
    step_no++;
    rst              = 1'b1;
    bus.load_use     = 1'b1;
    bus.m_mispredict = 1'b1;
    bus.m_valA       = 64'h99;
    bus.w_ret        = 1'b1;
    bus.w_valM       = 64'h98;
    #2;
    check("ctl_rst", {61'd0, bus.f_stall, bus.d_stall, bus.d_bubble}, 64'd0);
    exp_q.push_back({64'h20, 2'd0, 3'd1});
    exp_stall_cnt  = 32'd0;
    exp_bubble_cnt = 32'd0;
    @(posedge clk);
    #1;
    compare_regs();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    step_no        = 0;
    exp_stall_cnt  = 32'd0;
    exp_bubble_cnt = 32'd0;
    rst            = 1'b1;
    bus.load_use     = 1'b0;
    bus.m_mispredict = 1'b0;
    bus.m_valA       = 64'd0;
    bus.w_ret        = 1'b0;
    bus.w_valM       = 64'd0;
    fetch(4'd1, 64'd0, 64'h21);
    @(negedge clk);
    reset_step();

    // Sequential stream, load/use hold, taken jXX and mispredict repair.
    fetch(4'd1, 64'd0, 64'h21);      step(0, 0, 0, 0, 0, 3'b000, 64'h21, 2'd0, 3'd1);
    fetch(4'd1, 64'd0, 64'h22);      step(0, 0, 0, 0, 0, 3'b000, 64'h22, 2'd0, 3'd1);
    fetch(4'd1, 64'd0, 64'h23);      step(1, 0, 0, 0, 0, 3'b110, 64'h22, 2'd0, 3'd1);
                                     step(0, 0, 0, 0, 0, 3'b000, 64'h23, 2'd0, 3'd1);
    fetch(4'd7, 64'h40, 64'h2c);     step(0, 0, 0, 0, 0, 3'b000, 64'h40, 2'd0, 3'd1);
    fetch(4'd1, 64'd0, 64'h41);      step(0, 0, 0, 0, 0, 3'b000, 64'h41, 2'd0, 3'd1);
    fetch(4'd1, 64'd0, 64'h42);      step(0, 1, 64'h29, 0, 0, 3'b001, 64'h29, 2'd0, 3'd1);

    // call then ret, three RET_WAIT cycles with a halt on the wrong path.
    fetch(4'd8, 64'h30, 64'h32);     step(0, 0, 0, 0, 0, 3'b000, 64'h30, 2'd0, 3'd1);
    fetch(4'd9, 64'd0, 64'h31);      step(0, 0, 0, 0, 0, 3'b000, 64'h31, 2'd1, 3'd1);
    fetch(4'd0, 64'd0, 64'd0);
    for (int i = 0; i < 3; i++)      step(0, 0, 0, 0, 0, 3'b101, 64'h31, 2'd1, 3'd1);
    step(1, 0, 0, 1, 64'h50, 3'b000, 64'h50, 2'd0, 3'd1);

    // Mispredict beats a simultaneous ret; load_use delays RET_WAIT entry.
    fetch(4'd9, 64'd0, 64'h51);      step(0, 0, 0, 0, 0, 3'b000, 64'h51, 2'd1, 3'd1);
    step(0, 1, 64'h60, 1, 64'h70, 3'b001, 64'h60, 2'd0, 3'd1);
    fetch(4'd9, 64'd0, 64'h61);      step(1, 0, 0, 0, 0, 3'b110, 64'h60, 2'd0, 3'd1);
                                     step(0, 0, 0, 0, 0, 3'b000, 64'h61, 2'd1, 3'd1);
    step(0, 0, 0, 1, 64'h29, 3'b000, 64'h29, 2'd0, 3'd1);

    // halt: four DRAIN cycles, then HALT ignores mispredict and ret.
    fetch(4'd0, 64'd0, 64'h2a);      step(0, 0, 0, 0, 0, 3'b000, 64'h29, 2'd2, 3'd2);
    for (int i = 0; i < 4; i++)
      step(0, 0, 0, 0, 0, 3'b101, 64'h29, (i < 3) ? 2'd2 : 2'd3, 3'd2);
    fetch(4'd1, 64'd0, 64'h2a);      step(0, 1, 64'h77, 0, 0, 3'b101, 64'h29, 2'd3, 3'd2);
                                     step(0, 0, 0, 1, 64'h88, 3'b101, 64'h29, 2'd3, 3'd2);

    // Reset out of HALT, then mispredict cancels a drain in its second cycle.
    reset_step();
    fetch(4'd0, 64'd0, 64'h21);      step(0, 0, 0, 0, 0, 3'b000, 64'h20, 2'd2, 3'd2);
                                     step(0, 0, 0, 0, 0, 3'b101, 64'h20, 2'd2, 3'd2);
    step(0, 1, 64'h29, 0, 0, 3'b001, 64'h29, 2'd0, 3'd1);

    // imem error and invalid instruction statuses, reset mid-DRAIN.
    fetch(4'd1, 64'd0, 64'h2a);  bus.f_imem_error = 1'b1;
    step(0, 0, 0, 0, 0, 3'b000, 64'h29, 2'd2, 3'd3);
    fetch(4'd1, 64'd0, 64'h2a);  step(0, 1, 64'h30, 0, 0, 3'b001, 64'h30, 2'd0, 3'd1);
    fetch(4'd1, 64'd0, 64'h31);  bus.f_instr_valid = 1'b0;
    step(0, 0, 0, 0, 0, 3'b000, 64'h30, 2'd2, 3'd4);
    step(0, 0, 0, 0, 0, 3'b101, 64'h30, 2'd2, 3'd4);
    reset_step();
    fetch(4'd1, 64'd0, 64'h21);      step(0, 0, 0, 0, 0, 3'b000, 64'h21, 2'd0, 3'd1);

    check("queue_drained", {32'd0, 32'(exp_q.size())}, 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
